// File: rtl/seg_msg_scroller_if.sv
// Bus bundle for seg_msg_scroller.
//   en       : run enable
//   mode     : 00 scroll left, 01 scroll right, 10 blink, 11 freeze
//   wr_en    : message write strobe
//   wr_addr  : character index to write
//   wr_data  : active-low segment code, bit order gfedcba
//   seg      : NUM_DIGITS*7 segment lines, digit k on seg[7k+6:7k], k=0 leftmost
//   step     : one-cycle pulse per step
//   wrap     : one-cycle pulse when a scroll step returns the position to 0
// master drives control and writes; slave is the scroller itself.
interface seg_msg_scroller_if #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned MSG_LEN    = 24
);
   localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

   logic                    en;
   logic [1:0]              mode;
   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [6:0]              wr_data;
   logic [NUM_DIGITS*7-1:0] seg;
   logic                    step;
   logic                    wrap;

   modport master (
      output en, mode, wr_en, wr_addr, wr_data,
      input  seg, step, wrap
   );

   modport slave (
      input  en, mode, wr_en, wr_addr, wr_data,
      output seg, step, wrap
   );
endinterface

// File: rtl/seg_msg_scroller.sv
// Scrolling / blinking message driver for a row of 7-segment digits.
// A MSG_LEN-character buffer is written through the bus at any time; while
// enabled, a window of NUM_DIGITS characters starting at pos is shown and pos
// moves once every TICK_DIV clocks according to mode. After a scroll wraps to
// position 0 the window is held for DWELL_STEPS extra steps.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seg_msg_scroller_if slave (en, mode, wr_*, seg, step, wrap)
module seg_msg_scroller #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned MSG_LEN     = 24,
   parameter int unsigned TICK_DIV    = 25_000_000,
   parameter int unsigned DWELL_STEPS = 2
) (
   input logic               clk,
   input logic               rst,
   seg_msg_scroller_if.slave bus
);
   localparam int unsigned AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int unsigned AW1 = AW + 1;
   localparam int unsigned CW  = $clog2(TICK_DIV);
   localparam int unsigned DW  = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;

   localparam logic [AW1-1:0] MsgLenW = AW1'(MSG_LEN);
   localparam logic [AW-1:0]  PosLast = AW'(MSG_LEN - 1);
   localparam logic [CW-1:0]  TickMax = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0]  TickPre = CW'(TICK_DIV - 2);
   localparam logic [DW-1:0]  DwLast  = DW'((DWELL_STEPS > 0) ? DWELL_STEPS - 1 : 0);

   typedef enum logic [1:0] {StIdle, StRun, StDwell} state_e;

   state_e                  state_q;
   logic [AW-1:0]           pos_q;
   logic [CW-1:0]           cnt_q;
   logic [DW-1:0]           dwell_q;
   logic                    blank_q;
   logic [NUM_DIGITS*7-1:0] seg_q;
   logic                    step_q;
   logic                    wrap_q;
   logic [6:0]              msg_buf [MSG_LEN];

   logic                    wr_ok;
   logic                    scroll;
   logic [AW-1:0]           pos_scr;
   logic [AW1-1:0]          rd_idx;
   logic [NUM_DIGITS*7-1:0] seg_nxt;

   always_comb begin
      wr_ok   = bus.wr_en && ({1'b0, bus.wr_addr} < MsgLenW);
      scroll  = (bus.mode == 2'b00) || (bus.mode == 2'b01);
      if (bus.mode[0]) begin
         pos_scr = (pos_q == '0) ? PosLast : pos_q - 1'b1;
      end else begin
         pos_scr = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
      end
   end

   // Window index is pos+k with a single conditional wrap; k < NUM_DIGITS <= MSG_LEN
   // guarantees one subtraction is enough.
   always_comb begin
      seg_nxt = '1;
      rd_idx  = '0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         rd_idx = {1'b0, pos_q} + AW1'(k);
         if (rd_idx >= MsgLenW) rd_idx = rd_idx - MsgLenW;
         if (state_q != StIdle && !blank_q) seg_nxt[7*k +: 7] = msg_buf[rd_idx[AW-1:0]];
      end
   end

   // step_q is high exactly while cnt_q == TickMax, so it doubles as the internal tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MSG_LEN); i++) msg_buf[i] <= 7'h7F;
         state_q <= StIdle;
         pos_q   <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
         blank_q <= 1'b0;
         seg_q   <= '1;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         if (wr_ok) msg_buf[bus.wr_addr] <= bus.wr_data;
         seg_q  <= seg_nxt;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
         if (bus.mode != 2'b10) blank_q <= 1'b0;

         if (state_q == StIdle) begin
            cnt_q <= '0;
            if (bus.en) begin
               state_q <= StRun;
               pos_q   <= '0;
               blank_q <= 1'b0;
               dwell_q <= '0;
            end
         end else if (!bus.en) begin
            // Leaving wins over any step ending in this cycle.
            state_q <= StIdle;
            pos_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            blank_q <= 1'b0;
         end else begin
            cnt_q  <= (cnt_q == TickMax) ? '0 : cnt_q + 1'b1;
            step_q <= (cnt_q == TickPre);
            if (step_q) begin
               case (state_q)
                  StRun: begin
                     if (scroll) begin
                        pos_q <= pos_scr;
                        if (pos_scr == '0 && pos_q != '0) begin
                           wrap_q <= 1'b1;
                           if (DWELL_STEPS > 0) begin
                              state_q <= StDwell;
                              dwell_q <= '0;
                           end
                        end
                     end else if (bus.mode == 2'b10) begin
                        blank_q <= ~blank_q;
                     end
                  end
                  StDwell: begin
                     if (dwell_q == DwLast) state_q <= StRun;
                     else dwell_q <= dwell_q + 1'b1;
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

   assign bus.seg  = seg_q;
   assign bus.step = step_q;
   assign bus.wrap = wrap_q;
endmodule

// File: doc/seg_msg_scroller.md
SEG_MSG_SCROLLER -- requirements
Module: seg_msg_scroller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of 7-segment digits driven.
REQ-002 SHALL have parameter MSG_LEN, default 24: message buffer depth in characters; legal range NUM_DIGITS <= MSG_LEN.
REQ-003 SHALL have parameter TICK_DIV, default 25_000_000: clk cycles per step; legal range TICK_DIV >= 2.
REQ-004 SHALL have parameter DWELL_STEPS, default 2: extra steps held at pos 0 after each wrap; legal range >= 0.
REQ-005 SHALL have port clk, input, 1: system clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1: run enable.
REQ-008 SHALL have port mode, input, 2: 00 scroll left, 01 scroll right, 10 blink, 11 freeze.
REQ-009 SHALL have port wr_en, input, 1: message write strobe.
REQ-010 SHALL have port wr_addr, input, $clog2(MSG_LEN): character index.
REQ-011 SHALL have port wr_data, input, 7: segment code, active-low, bit order gfedcba.
REQ-012 SHALL have port seg, output, NUM_DIGITS*7: digit k on seg[7k+6:7k]; k=0 leftmost.
REQ-013 SHALL have port step, output, 1: one-cycle pulse per step.
REQ-014 SHALL have port wrap, output, 1: one-cycle pulse when a scroll step returns pos to 0.

Function
REQ-015 Buffer SHALL be MSG_LEN x 7 registers; wr_en writes wr_data at wr_addr on the clk edge in any state or mode; wr_addr >= MSG_LEN SHALL be ignored.
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 outside IDLE; step SHALL be high in the cycle counter == TICK_DIV-1, after which the counter SHALL return to 0; in IDLE the counter SHALL be held at 0.
REQ-017 FSM states SHALL be IDLE, RUN, DWELL.
REQ-018 IDLE -> RUN SHALL occur on the edge where en=1, with pos=0 and blank_phase=0.
REQ-019 RUN or DWELL -> IDLE SHALL occur on the edge where en=0; pos, counter and blank_phase SHALL clear, and a step in that cycle SHALL have no effect.
REQ-020 RUN SHALL update pos on the edge ending a step cycle: mode 00 -> pos = (pos+1) mod MSG_LEN; mode 01 -> pos = (pos==0) ? MSG_LEN-1 : pos-1; mode 10 -> toggle blank_phase, pos unchanged; mode 11 -> no change.
REQ-021 A scroll step that sets pos to 0 from a nonzero pos SHALL assert wrap for exactly the first cycle in which pos == 0, and SHALL enter DWELL if DWELL_STEPS > 0, otherwise remain in RUN.
REQ-022 DWELL SHALL freeze pos and count DWELL_STEPS steps, then return to RUN on the edge ending the last counted step; mode changes during DWELL SHALL take effect only after returning to RUN.
REQ-023 blank_phase SHALL clear on the first edge where mode != 10.
REQ-024 Digit k SHALL display buf[(pos+k) mod MSG_LEN]; the index SHALL be computed at $clog2(MSG_LEN)+1 bits with at most one subtraction of MSG_LEN.
REQ-025 Digit k SHALL be 7'h7F in IDLE, and SHALL be 7'h7F when blank_phase=1.
REQ-026 seg SHALL be registered: the value in cycle t+1 reflects state, pos, blank_phase and buffer contents in cycle t.
REQ-027 A write and a step in the same cycle SHALL both take effect.

Reset
REQ-028 rst SHALL asynchronously set all buffer entries to 7'h7F, state IDLE, pos 0, counter 0, blank_phase 0, seg all ones, step 0, wrap 0.
REQ-029 After rst deasserts, the block SHALL remain in IDLE until en is sampled high.

Verification
REQ-030 Bench parameters SHALL be NUM_DIGITS=4, MSG_LEN=6, TICK_DIV=4, DWELL_STEPS=1.
REQ-031 Reset, no writes, en=1, mode 00 -> seg = 28'hFFFFFFF throughout; step pulses every 4 cycles.
REQ-032 Write H,A,P,P,Y,blank (09,08,0C,0C,11,7F), en=1, mode 00 -> windows HAPP, APPY, PPY_, PY_H, Y_HA, _HAP, then HAPP with wrap; HAPP held one extra step before APPY.
REQ-033 Same message, mode 01 -> pos sequence 0,5,4,3; the window after the first step is _HAP.
REQ-034 Same message, mode 10 -> seg alternates HAPP and all-blank on each step; switching to mode 11 -> HAPP held with no further changes.
REQ-035 en dropped at pos 3 -> IDLE on the next edge and seg all ones one cycle later; re-asserting en -> restart at HAPP.
REQ-036 rst pulsed mid-scroll -> seg all ones immediately, with no clock edge; after release, en=1 -> all blank, since the buffer is cleared.
